// File: rtl/global_def.sv
// Shared definitions for the fetch stage: bus widths, constants and FSM state encodings.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package global_def;

   localparam int ADDR_BUS = 32;
   localparam int INST_BUS = 32;

   localparam logic [INST_BUS-1:0] ZERO_WORD = 32'h0000_0000;
   localparam logic                TRUE      = 1'b1;
   localparam logic                FALSE     = 1'b0;

   // Fetch FSM states
   typedef enum logic [1:0] {
      IF_IDLE = 2'd0,
      IF_REQ  = 2'd1,
      IF_KILL = 2'd2
   } if_state_t;

   // Instruction addresses are word aligned; the low two bits of a target are dropped
   function automatic logic [ADDR_BUS-1:0] word_align(input logic [ADDR_BUS-1:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/if_pc_gen.sv
// Fetch PC generator: owns fetch_pc, the deferred-redirect registers and the next-PC mux.
// Latency: next_pc is combinational from the controls; fetch_pc follows one clock later.
// Backpressure: none of its own; fetch_pc only moves when the top asserts a control.
module if_pc_gen
   import global_def::*;
#(
   parameter logic [ADDR_BUS-1:0] RESET_PC = 32'hBFC0_0000,
   parameter logic [ADDR_BUS-1:0] PC_STEP  = 32'd4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                advance,      // response accepted: step, or apply a pending redirect
   input  logic                jump,         // load the branch target right now
   input  logic                arm,          // remember the branch target, apply it later
   input  logic                resume,       // squash finished: load the remembered target
   input  logic [ADDR_BUS-1:0] branch_addr,
   output logic [ADDR_BUS-1:0] fetch_pc,
   output logic [ADDR_BUS-1:0] next_pc
);

   logic                redirect_pending;
   logic [ADDR_BUS-1:0] redirect_pc;

   // Next-PC selection; an immediate jump beats everything, then a finished squash, then a step
   always_comb begin
      next_pc = fetch_pc;
      if (jump) begin
         next_pc = word_align(branch_addr);
      end else if (resume) begin
         next_pc = redirect_pc;
      end else if (advance) begin
         next_pc = redirect_pending ? redirect_pc : fetch_pc + PC_STEP;
      end
   end

   // PC register; wraps modulo 2^32 naturally through the adder width
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
      end else begin
         fetch_pc <= next_pc;
      end
   end

   // Deferred redirect: armed by a branch, consumed by the next PC update that uses it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         redirect_pending <= FALSE;
         redirect_pc      <= ZERO_WORD;
      end else if (arm) begin
         redirect_pending <= TRUE;
         redirect_pc      <= word_align(branch_addr);
      end else if (advance || resume || jump) begin
         redirect_pending <= FALSE;
      end
   end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: drives the ROM request, registers responses into the IF/ID register.
// Latency: one clock from accepted ROM response to id_valid/id_pc/id_inst; one instruction per clock.
// Backpressure: stall holds IF/ID and the ROM address; redirects squash (or, with
// IF_BRANCH_DELAY_SLOT_EN defined, defer past one delay-slot instruction).
module if_fetch_stage
   import global_def::*;
#(
   parameter logic [ADDR_BUS-1:0] RESET_PC = 32'hBFC0_0000,
   parameter logic [ADDR_BUS-1:0] PC_STEP  = 32'd4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
   input  logic                branch_flag,
   input  logic [ADDR_BUS-1:0] branch_addr,
   output logic                rom_en,
   output logic [ADDR_BUS-1:0] rom_addr,
   input  logic                rom_ready,
   input  logic [INST_BUS-1:0] rom_data,
   output logic                id_valid,
   output logic [ADDR_BUS-1:0] id_pc,
   output logic [INST_BUS-1:0] id_inst
);

   if_state_t           state;
   logic [ADDR_BUS-1:0] fetch_pc;
   logic [ADDR_BUS-1:0] next_pc;

   logic load;           // IF/ID may be overwritten this cycle
   logic redirect_take;  // ID is redirecting this cycle
   logic accept;         // ROM response is consumed this cycle
   logic deliver;        // consumed response is written into IF/ID as live
   logic enter_kill;     // outstanding request must be discarded when it returns
   logic pc_advance;
   logic pc_jump;
   logic pc_arm;
   logic pc_resume;

   // Handshake and redirect qualification shared by both redirect flavours
   always_comb begin
      load          = !id_valid || !stall;
      redirect_take = branch_flag && id_valid && !stall;
      accept        = (state == IF_REQ) && rom_ready && load;
   end

`ifdef IF_BRANCH_DELAY_SLOT_EN
   // Delay slot: the next response still goes to ID; the target applies on the fetch after it
   always_comb begin
      deliver    = accept;
      enter_kill = FALSE;
      pc_advance = accept;
      pc_jump    = accept && redirect_take;
      pc_arm     = (state == IF_REQ) && redirect_take && !accept;
      pc_resume  = FALSE;
   end
`else
   // Squash: a same-cycle response is dropped, an outstanding one is drained through KILL
   always_comb begin
      deliver    = accept && !redirect_take;
      enter_kill = (state == IF_REQ) && redirect_take && !rom_ready;
      pc_advance = deliver;
      pc_jump    = (state == IF_REQ) && redirect_take && rom_ready;
      pc_arm     = enter_kill;
      pc_resume  = (state == IF_KILL) && rom_ready;
   end
`endif

   if_pc_gen #(
      .RESET_PC (RESET_PC),
      .PC_STEP  (PC_STEP)
   ) u_pc_gen (
      .clk         (clk),
      .rst         (rst),
      .advance     (pc_advance),
      .jump        (pc_jump),
      .arm         (pc_arm),
      .resume      (pc_resume),
      .branch_addr (branch_addr),
      .fetch_pc    (fetch_pc),
      .next_pc     (next_pc)
   );

   // Fetch FSM with registered ROM request and IF/ID register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IF_IDLE;
         rom_en   <= FALSE;
         rom_addr <= ZERO_WORD;
         id_valid <= FALSE;
         id_pc    <= ZERO_WORD;
         id_inst  <= ZERO_WORD;
      end else begin
         case (state)
            IF_IDLE: begin
               state    <= IF_REQ;
               rom_en   <= TRUE;
               rom_addr <= next_pc;
            end
            IF_REQ: begin
               // rom_addr tracks fetch_pc, so it only moves when the PC does
               rom_en   <= TRUE;
               rom_addr <= next_pc;
               if (enter_kill) begin
                  state <= IF_KILL;
               end
               if (deliver) begin
                  id_valid <= TRUE;
                  id_pc    <= fetch_pc;
                  id_inst  <= rom_data;
               end else if (load) begin
                  // bubble, dropped response, or squash entry
                  id_valid <= FALSE;
                  id_inst  <= ZERO_WORD;
               end
            end
            IF_KILL: begin
               // keep presenting the old address until its response is thrown away
               rom_en   <= TRUE;
               rom_addr <= next_pc;
               id_valid <= FALSE;
               id_inst  <= ZERO_WORD;
               if (rom_ready) begin
                  state <= IF_REQ;
               end
            end
            default: begin
               state    <= IF_IDLE;
               rom_en   <= FALSE;
               id_valid <= FALSE;
               id_inst  <= ZERO_WORD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: table of per-cycle vectors checked through a scoreboard queue,
// plus hand-written asynchronous reset sequences.
// Expectations for redirect rows follow IF_BRANCH_DELAY_SLOT_EN when it is defined.
`timescale 1ns/1ps
module tb_if_fetch_stage;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        branch_flag;
   logic [31:0] branch_addr;
   logic        rom_en;
   logic [31:0] rom_addr;
   logic        rom_ready;
   logic [31:0] rom_data;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_inst;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic        stall;
      logic        bf;
      logic [31:0] baddr;
      logic        rdy;
      logic        exp_en;
      logic [31:0] exp_addr;
      logic        exp_vld;
      logic [31:0] exp_pc;
   } vec_t;

   typedef struct {
      int          row;
      logic        en;
      logic [31:0] addr;
      logic        vld;
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   vec_t vecs[24];
   exp_t sb[$];

   if_fetch_stage dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .branch_flag (branch_flag),
      .branch_addr (branch_addr),
      .rom_en      (rom_en),
      .rom_addr    (rom_addr),
      .rom_ready   (rom_ready),
      .rom_data    (rom_data),
      .id_valid    (id_valid),
      .id_pc       (id_pc),
      .id_inst     (id_inst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM content: a recognisable word per address, distinct from the address itself
   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a ^ 32'h5A5A_0F0F;
   endfunction

   assign rom_data = inst_of(rom_addr);

   function automatic vec_t mk(input logic st, input logic bf, input logic [31:0] ba,
                               input logic rdy, input logic [31:0] addr,
                               input logic vld, input logic [31:0] pc);
      vec_t v;
      v.stall    = st;
      v.bf       = bf;
      v.baddr    = ba;
      v.rdy      = rdy;
      v.exp_en   = 1'b1;
      v.exp_addr = addr;
      v.exp_vld  = vld;
      v.exp_pc   = pc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " rom_en"},   {31'b0, rom_en},   32'h0);
      chk({tag, " rom_addr"}, rom_addr,          32'h0);
      chk({tag, " id_valid"}, {31'b0, id_valid}, 32'h0);
      chk({tag, " id_pc"},    id_pc,             32'h0);
      chk({tag, " id_inst"},  id_inst,           32'h0);
   endtask

   // Called at a negedge: drive one row, push its expectation, compare after the edge
   task automatic run_row(input int idx);
      exp_t e;
      exp_t got;
      string tag;
      stall       = vecs[idx].stall;
      branch_flag = vecs[idx].bf;
      branch_addr = vecs[idx].baddr;
      rom_ready   = vecs[idx].rdy;
      e.row  = idx;
      e.en   = vecs[idx].exp_en;
      e.addr = vecs[idx].exp_addr;
      e.vld  = vecs[idx].exp_vld;
      e.pc   = vecs[idx].exp_pc;
      e.inst = vecs[idx].exp_vld ? inst_of(vecs[idx].exp_pc) : 32'h0;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL scoreboard: empty at row %0d", idx);
      end else begin
         got = sb.pop_front();
         tag = $sformatf("row%0d", got.row);
         chk({tag, " rom_en"},   {31'b0, rom_en},   {31'b0, got.en});
         chk({tag, " rom_addr"}, rom_addr,          got.addr);
         chk({tag, " id_valid"}, {31'b0, id_valid}, {31'b0, got.vld});
         chk({tag, " id_inst"},  id_inst,           got.inst);
         if (got.vld) chk({tag, " id_pc"}, id_pc, got.pc);
      end
      @(negedge clk);
   endtask

   initial begin
      rst         = 1'b0;
      stall       = 1'b0;
      branch_flag = 1'b0;
      branch_addr = 32'h0;
      rom_ready   = 1'b0;

      // Vector table: inputs for one clock and the outputs expected after that edge
      vecs[0]  = mk(0, 0, 32'h0,        1, 32'hBFC0_0000, 0, 32'h0);
      vecs[1]  = mk(0, 0, 32'h0,        1, 32'hBFC0_0004, 1, 32'hBFC0_0000);
      vecs[2]  = mk(0, 0, 32'h0,        1, 32'hBFC0_0008, 1, 32'hBFC0_0004);
      vecs[3]  = mk(1, 0, 32'h0,        1, 32'hBFC0_0008, 1, 32'hBFC0_0004);
      vecs[4]  = mk(1, 0, 32'h0,        1, 32'hBFC0_0008, 1, 32'hBFC0_0004);
      vecs[5]  = mk(1, 0, 32'h0,        1, 32'hBFC0_0008, 1, 32'hBFC0_0004);
      vecs[6]  = mk(0, 0, 32'h0,        1, 32'hBFC0_000C, 1, 32'hBFC0_0008);
      vecs[7]  = mk(0, 0, 32'h0,        0, 32'hBFC0_000C, 0, 32'h0);
      vecs[8]  = mk(0, 0, 32'h0,        0, 32'hBFC0_000C, 0, 32'h0);
      vecs[9]  = mk(0, 0, 32'h0,        1, 32'hBFC0_0010, 1, 32'hBFC0_000C);
      vecs[10] = mk(0, 0, 32'h0,        1, 32'hBFC0_0014, 1, 32'hBFC0_0010);
      vecs[11] = mk(0, 1, 32'h8000_0000, 0, 32'hBFC0_0014, 0, 32'h0);
      vecs[12] = mk(0, 0, 32'h0,        0, 32'hBFC0_0014, 0, 32'h0);
`ifdef IF_BRANCH_DELAY_SLOT_EN
      vecs[13] = mk(0, 0, 32'h0,        1, 32'h8000_0000, 1, 32'hBFC0_0014);
`else
      vecs[13] = mk(0, 0, 32'h0,        1, 32'h8000_0000, 0, 32'h0);
`endif
      vecs[14] = mk(0, 0, 32'h0,        1, 32'h8000_0004, 1, 32'h8000_0000);
`ifdef IF_BRANCH_DELAY_SLOT_EN
      vecs[15] = mk(0, 1, 32'h0000_0103, 1, 32'h0000_0100, 1, 32'h8000_0004);
`else
      vecs[15] = mk(0, 1, 32'h0000_0103, 1, 32'h0000_0100, 0, 32'h0);
`endif
      vecs[16] = mk(0, 0, 32'h0,        1, 32'h0000_0104, 1, 32'h0000_0100);
`ifdef IF_BRANCH_DELAY_SLOT_EN
      vecs[17] = mk(0, 1, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFC, 1, 32'h0000_0104);
`else
      vecs[17] = mk(0, 1, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFC, 0, 32'h0);
`endif
      vecs[18] = mk(0, 0, 32'h0,        1, 32'h0000_0000, 1, 32'hFFFF_FFFC);
      vecs[19] = mk(0, 0, 32'h0,        1, 32'h0000_0004, 1, 32'h0000_0000);
      vecs[20] = mk(1, 1, 32'h0000_0040, 1, 32'h0000_0004, 1, 32'h0000_0000);
      vecs[21] = mk(0, 0, 32'h0,        1, 32'h0000_0008, 1, 32'h0000_0004);
      vecs[22] = mk(0, 0, 32'h0,        0, 32'h0000_0008, 0, 32'h0);
      vecs[23] = mk(0, 1, 32'h0000_0040, 1, 32'h0000_000C, 1, 32'h0000_0008);

      // Power-on reset
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 24; i++) begin
         run_row(i);
      end

      // Reset mid-request with a response on the bus: outputs clear without a clock
      rom_ready = 1'b1;
      stall     = 1'b0;
      branch_flag = 1'b0;
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk_zero("arst_rdy1");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("arst_rdy1 first rom_en",   {31'b0, rom_en}, 32'h1);
      chk("arst_rdy1 first rom_addr", rom_addr,        32'hBFC0_0000);
      @(posedge clk);
      #1;
      chk("arst_rdy1 first id_pc",    id_pc,           32'hBFC0_0000);
      chk("arst_rdy1 first id_inst",  id_inst,         inst_of(32'hBFC0_0000));

      // Reset mid-request while the ROM has not answered
      @(negedge clk);
      rom_ready = 1'b0;
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk_zero("arst_rdy0");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("arst_rdy0 first rom_addr", rom_addr,          32'hBFC0_0000);
      chk("arst_rdy0 id_valid",       {31'b0, id_valid}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
